// File: rtl/ariane_pkg.sv
// Minimal slice of ariane_pkg: the LSU control word and functional-unit
// operation types shared between the LSU address stage and the store unit.
package ariane_pkg;

    localparam int unsigned VLEN          = 64;
    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef enum logic [3:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef enum logic [7:0] {
        ADD,
        SUB,
        LD,
        LW,
        SD,
        SW,
        SH,
        SB,
        AMO_ADDW,
        AMO_ADDD,
        AMO_SWAPW
    } fu_op;

    typedef struct packed {
        logic                     valid;
        logic [VLEN-1:0]          vaddr;
        logic                     overflow;
        logic [XLEN-1:0]          data;
        logic [XLEN/8-1:0]        be;
        fu_t                      fu;
        fu_op                     operation;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } lsu_ctrl_t;

endpackage

// File: rtl/store_issue_queue.sv
// Registered FIFO of store/AMO requests between the LSU address stage and the
// store unit; ready_o comes from the registered count only, so no fall-through.
module store_issue_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  lsu_ctrl_t                lsu_ctrl_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output lsu_ctrl_t                lsu_ctrl_o,
    input  logic                     pop_i,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   usage_o
);

    localparam int unsigned     PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    lsu_ctrl_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             push;
    logic             pop;

    assign empty_o    = (cnt_q == '0);
    assign valid_o    = !empty_o;
    assign ready_o    = (cnt_q < FULL_CNT);
    assign usage_o    = cnt_q;
    assign lsu_ctrl_o = empty_o ? lsu_ctrl_t'('0) : mem_q[rd_ptr_q];

    // A flush wins over any same-cycle push or pop.
    assign push = valid_i && ready_o && !flush_i;
    assign pop  = pop_i && valid_o && !flush_i;

    // Storage carries no reset; pointers and count decide what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= lsu_ctrl_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_store_issue_queue.sv
// Directed bench for store_issue_queue: a scoreboard queue of expected heads
// checked by a monitor every cycle, plus per-cycle status checks.
module tb_store_issue_queue;
    import ariane_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic                   clk_i      = 1'b0;
    logic                   rst_ni     = 1'b0;
    logic                   flush_i    = 1'b0;
    logic                   valid_i    = 1'b0;
    logic                   pop_i      = 1'b0;
    lsu_ctrl_t              lsu_ctrl_i = '0;
    logic                   ready_o;
    logic                   valid_o;
    logic                   empty_o;
    lsu_ctrl_t              lsu_ctrl_o;
    logic [$clog2(DEPTH):0] usage_o;

    int        checks   = 0;
    int        failures = 0;
    lsu_ctrl_t exp_q[$];
    lsu_ctrl_t rot[3];

    always #5 clk_i = ~clk_i;

    store_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .lsu_ctrl_i (lsu_ctrl_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .lsu_ctrl_o (lsu_ctrl_o),
        .pop_i      (pop_i),
        .empty_o    (empty_o),
        .usage_o    (usage_o)
    );

    function automatic lsu_ctrl_t mk(input logic [2:0] id, input logic [7:0] tag);
        lsu_ctrl_t r;
        r           = '0;
        r.valid     = 1'b1;
        r.vaddr     = 64'h8000_0000_0000_1000 + 64'(tag) * 64'd8;
        r.data      = {8{tag}};
        r.be        = 8'hFF;
        r.fu        = STORE;
        r.operation = SD;
        r.trans_id  = id;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic chk_st(input string name, input logic v, input logic r, input int u);
        chk({name, "_valid"}, 64'(valid_o), 64'(v));
        chk({name, "_ready"}, 64'(ready_o), 64'(r));
        chk({name, "_usage"}, 64'(usage_o), 64'(u));
        chk({name, "_empty"}, 64'(empty_o), 64'(!v));
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input lsu_ctrl_t c, input bit accepted);
        valid_i    = 1'b1;
        lsu_ctrl_i = c;
        if (accepted) exp_q.push_back(c);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk_i);
            if (rst_ni && valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL head_unexpected: got trans_id %0d vaddr %0h, required no entry",
                             lsu_ctrl_o.trans_id, lsu_ctrl_o.vaddr);
                end else begin
                    if (lsu_ctrl_o !== exp_q[0]) begin
                        failures++;
                        $display("FAIL head: got trans_id %0d vaddr %0h, required trans_id %0d vaddr %0h",
                                 lsu_ctrl_o.trans_id, lsu_ctrl_o.vaddr,
                                 exp_q[0].trans_id, exp_q[0].vaddr);
                    end
                    if (pop_i && !flush_i) void'(exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic watchdog();
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    endtask

    initial begin
        fork
            monitor();
            watchdog();
        join_none

        // Reset state
        #3;
        chk_st("reset", 1'b0, 1'b1, 0);
        chk("reset_data", 64'(lsu_ctrl_o === '0), 64'd1);
        cyc();
        rst_ni = 1'b1;

        // Push A, no fall-through
        offer(mk(3'd3, 8'h0A), 1'b1);
        @(negedge clk_i);
        chk_st("a_same_cycle", 1'b0, 1'b1, 0);
        cyc();
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_st("a_next", 1'b1, 1'b1, 1);
        chk("a_trans_id", 64'(lsu_ctrl_o.trans_id), 64'd3);
        cyc();

        // Push B, then C held while full
        offer(mk(3'd5, 8'h0B), 1'b1);
        @(negedge clk_i);
        chk_st("b_push", 1'b1, 1'b1, 1);
        cyc();
        offer(mk(3'd6, 8'h0C), 1'b0);
        @(negedge clk_i);
        chk_st("full1", 1'b1, 1'b0, 2);
        cyc();
        @(negedge clk_i);
        chk_st("full2", 1'b1, 1'b0, 2);
        cyc();

        // Full: pop with C offered, C rejected
        pop_i = 1'b1;
        @(negedge clk_i);
        chk_st("full_pop", 1'b1, 1'b0, 2);
        cyc();
        pop_i = 1'b0;
        exp_q.push_back(lsu_ctrl_i);
        @(negedge clk_i);
        chk_st("after_full_pop", 1'b1, 1'b1, 1);
        chk("head_b", 64'(lsu_ctrl_o.trans_id), 64'd5);
        cyc();
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_st("c_in", 1'b1, 1'b0, 2);
        cyc();
        pop_i = 1'b1;
        @(negedge clk_i);
        cyc();
        pop_i = 1'b0;
        @(negedge clk_i);
        chk_st("usage1", 1'b1, 1'b1, 1);
        chk("head_c", 64'(lsu_ctrl_o.trans_id), 64'd6);
        cyc();

        // Simultaneous push/pop at usage 1, pointers wrap
        rot[0] = mk(3'd1, 8'h0D);
        rot[1] = mk(3'd2, 8'h0E);
        rot[2] = mk(3'd4, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            offer(rot[i], 1'b1);
            pop_i = 1'b1;
            @(negedge clk_i);
            chk_st("pushpop", 1'b1, 1'b1, 1);
            cyc();
        end
        valid_i = 1'b0;
        pop_i   = 1'b0;
        @(negedge clk_i);
        chk_st("after_pushpop", 1'b1, 1'b1, 1);
        chk("head_f", 64'(lsu_ctrl_o.trans_id), 64'd4);
        cyc();

        // Flush at usage 2 with a concurrent offer
        offer(mk(3'd7, 8'h10), 1'b1);
        @(negedge clk_i);
        cyc();
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_st("pre_flush", 1'b1, 1'b0, 2);
        cyc();
        flush_i = 1'b1;
        offer(mk(3'd0, 8'h11), 1'b0);
        @(negedge clk_i);
        cyc();
        flush_i = 1'b0;
        valid_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        chk_st("post_flush", 1'b0, 1'b1, 0);
        chk("post_flush_data", 64'(lsu_ctrl_o === '0), 64'd1);
        cyc();
        offer(mk(3'd2, 8'h12), 1'b1);
        @(negedge clk_i);
        cyc();
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_st("i_in", 1'b1, 1'b1, 1);
        chk("head_i", 64'(lsu_ctrl_o.trans_id), 64'd2);
        cyc();
        pop_i = 1'b1;
        @(negedge clk_i);
        cyc();
        pop_i = 1'b0;
        @(negedge clk_i);
        chk_st("i_out", 1'b0, 1'b1, 0);
        cyc();

        // Pop while empty is ignored
        pop_i = 1'b1;
        @(negedge clk_i);
        cyc();
        pop_i = 1'b0;
        @(negedge clk_i);
        chk_st("empty_pop", 1'b0, 1'b1, 0);
        cyc();

        // Asynchronous reset mid-cycle at usage 2
        offer(mk(3'd3, 8'h13), 1'b1);
        cyc();
        offer(mk(3'd5, 8'h14), 1'b1);
        cyc();
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_st("pre_reset", 1'b1, 1'b0, 2);
        cyc();
        #2;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        chk_st("async_reset", 1'b0, 1'b1, 0);
        chk("async_reset_data", 64'(lsu_ctrl_o === '0), 64'd1);
        cyc();
        rst_ni = 1'b1;
        offer(mk(3'd6, 8'h15), 1'b1);
        @(negedge clk_i);
        chk_st("l_same_cycle", 1'b0, 1'b1, 0);
        cyc();
        valid_i = 1'b0;
        @(negedge clk_i);
        chk_st("l_next", 1'b1, 1'b1, 1);
        chk("head_l", 64'(lsu_ctrl_o.trans_id), 64'd6);
        cyc();
        pop_i = 1'b1;
        @(negedge clk_i);
        cyc();
        pop_i = 1'b0;
        @(negedge clk_i);
        chk_st("final", 1'b0, 1'b1, 0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_issue_queue.md
STORE_ISSUE_QUEUE -- requirements
Module: store_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of lsu_ctrl_t entries held; power of two, >= 2.
REQ-002 SHALL have port clk_i  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port flush_i  input  1  discards all queued entries.
REQ-005 SHALL have port valid_i  input  1  upstream address-generation stage offers a store or AMO.
REQ-006 SHALL have port lsu_ctrl_i  input  lsu_ctrl_t  offered request.
REQ-007 SHALL have port ready_o  output  1  queue accepts lsu_ctrl_i this cycle.
REQ-008 SHALL have port valid_o  output  1  head entry present; drives the store unit valid input.
REQ-009 SHALL have port lsu_ctrl_o  output  lsu_ctrl_t  head entry; drives the store unit lsu_ctrl input.
REQ-010 SHALL have port pop_i  input  1  store unit consumed the head; driven by the store unit pop_st output.
REQ-011 SHALL have port empty_o  output  1  no entries held.
REQ-012 SHALL have port usage_o  output  $clog2(DEPTH)+1  number of entries held.

Function
REQ-013 SHALL perform a push when valid_i && ready_o && !flush_i, writing lsu_ctrl_i at the write pointer.
REQ-014 SHALL drive ready_o = (usage < DEPTH), derived from registered count only, with no combinational path from pop_i or valid_i.
REQ-015 SHALL perform a pop when pop_i && valid_o && !flush_i, advancing the read pointer.
REQ-016 SHALL drive valid_o = !empty_o and lsu_ctrl_o = entry at the read pointer; lsu_ctrl_o is '0 when empty.
REQ-017 SHALL NOT fall through: an entry pushed in cycle N appears on valid_o/lsu_ctrl_o in cycle N+1 at the earliest.
REQ-018 SHALL hold lsu_ctrl_o stable while valid_o && !pop_i; the head persists across store unit stall states (translation miss, store buffer full).
REQ-019 SHALL leave usage unchanged on a simultaneous push and pop; usage increments on push only and decrements on pop only.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; pointers are $clog2(DEPTH) bits wide.
REQ-021 SHALL ignore pop_i while empty: no pointer or count change.
REQ-022 SHALL ignore valid_i while full; upstream must hold the request until ready_o.
REQ-023 SHALL, on flush_i, set usage to 0 and both pointers to 0 on the next edge; any same-cycle push and pop are discarded.
REQ-024 SHALL NOT clear entry storage on flush or pop; only pointers and the count are authoritative.
REQ-025 SHALL keep usage_o <= DEPTH at all times.

Reset
REQ-026 SHALL, while rst_ni is low, asynchronously force: pointers 0, usage 0, valid_o 0, ready_o 1, empty_o 1, usage_o 0, lsu_ctrl_o '0.
REQ-027 SHALL, on reset mid-operation, drop all held entries; the first push after reset deasserts appears on valid_o one cycle later.

Structure
REQ-028 SHALL take lsu_ctrl_t and fu_op from ariane_pkg; no new package typedefs are required.
REQ-029 SHALL be a single flat module, instantiated between the LSU address stage and the store unit; no sub-modules.

Verification
REQ-030 SHALL cover: reset, then push A (trans_id=3) in cycle 0 -> valid_o=1 with trans_id 3 in cycle 1; usage_o=1; ready_o=1.
REQ-031 SHALL cover: DEPTH=2, push A and B back-to-back with no pop -> usage_o=2, ready_o=0; a third valid_i is held and not accepted until pop_i.
REQ-032 SHALL cover: full queue, push C and pop in the same cycle (ready_o=0) -> C is not accepted; usage_o goes to 1 and head becomes B.
REQ-033 SHALL cover: usage 1, simultaneous push and pop -> usage_o stays 1; head becomes the new entry; pointers wrap after 3 such cycles.
REQ-034 SHALL cover: usage 2, flush_i asserted together with valid_i -> next cycle usage_o=0, valid_o=0, and the pushed entry never appears.
REQ-035 SHALL cover: pop_i pulsed while empty -> no change; rst_ni dropped asynchronously mid-cycle at usage 2 -> empty_o=1 immediately.
